// File: rtl/glitch_wishbone.sv
// glitch_wishbone: Wishbone-slave clock glitcher that replaces clk_in on clk_out for a programmed window.
// Build option: define GLITCH_NOT_MODE_EN to make MODE 3 output ~clk_in; otherwise MODE 3 passes clk_in.
module glitch_wishbone (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] dat_i,
  input  logic [5:2] adr_i,
  output logic [7:0] dat_o,
  input  logic       stb_i,
  input  logic       we_i,
  output logic       ack_o,
  input  logic       clk_in,
  output logic       clk_out
);
  typedef enum logic [1:0] {IDLE, DELAY, WIDTH} state_t;
  state_t      state_q, state_d;
  logic [15:0] delay_q, delay_d, dly_cnt_q, dly_cnt_d;
  logic [7:0]  width_q, width_d, wid_cnt_q, wid_cnt_d;
  logic [7:0]  mode_q, mode_d, dat_q, dat_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  rdata;
  logic        wr, trig, glitch;
  always_comb begin
    wr        = stb_i & we_i;
    delay_d   = delay_q;
    width_d   = width_q;
    mode_d    = mode_q;
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    wid_cnt_d = wid_cnt_q;
    delay_d[7:0]  = (wr && adr_i == 4'd1) ? dat_i : delay_q[7:0];
    delay_d[15:8] = (wr && adr_i == 4'd2) ? dat_i : delay_q[15:8];
    width_d       = (wr && adr_i == 4'd3) ? dat_i : width_q;
    mode_d        = (wr && adr_i == 4'd4) ? dat_i : mode_q;
    trig = wr && adr_i == 4'd0 && dat_i[0] && state_q == IDLE;
    case (state_q)
      IDLE: if (trig) begin
        dly_cnt_d = delay_q;
        wid_cnt_d = width_q;
        state_d   = (delay_q != 16'd0) ? DELAY : (width_q != 8'd0) ? WIDTH : IDLE;
      end
      DELAY: begin
        dly_cnt_d = dly_cnt_q - 16'd1;
        state_d   = (dly_cnt_q != 16'd1) ? DELAY : (wid_cnt_q != 8'd0) ? WIDTH : IDLE;
      end
      WIDTH: begin
        wid_cnt_d = wid_cnt_q - 8'd1;
        state_d   = (wid_cnt_q == 8'd1) ? IDLE : WIDTH;
      end
      default: state_d = IDLE;
    endcase
    case (adr_i)
      4'd0:    rdata = {7'd0, state_q == IDLE};
      4'd1:    rdata = delay_q[7:0];
      4'd2:    rdata = delay_q[15:8];
      4'd3:    rdata = width_q;
      4'd4:    rdata = mode_q;
      default: rdata = 8'd0;
    endcase
    dat_d = (stb_i && !we_i) ? rdata : dat_q;
    ack_d = {ack_q[0], stb_i};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      width_q   <= '0;
      mode_q    <= '0;
      dly_cnt_q <= '0;
      wid_cnt_q <= '0;
      dat_q     <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      mode_q    <= mode_d;
      dly_cnt_q <= dly_cnt_d;
      wid_cnt_q <= wid_cnt_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
    end
  end
  // ack is stretched over two cycles so a master that drops a one-cycle strobe still sees it
  always_comb begin
    case (mode_q[1:0])
      2'd1:    glitch = 1'b0;
      2'd2:    glitch = 1'b1;
`ifdef GLITCH_NOT_MODE_EN
      2'd3:    glitch = ~clk_in;
`else
      2'd3:    glitch = clk_in;
`endif
      default: glitch = clk_in;
    endcase
  end
  assign clk_out = (state_q == WIDTH) ? glitch : clk_in;
  assign dat_o   = dat_q;
  assign ack_o   = |ack_q;
endmodule

// File: tb/tb_glitch_wishbone.sv
// tb_glitch_wishbone: randomized register and glitch-window checks against a cycle-count reference model.
module tb_glitch_wishbone;
  logic       clk_i = 1'b0, rst_ni = 1'b0, clk_in = 1'b0;
  logic [7:0] dat_i = '0;
  logic [5:2] adr_i = '0;
  logic       stb_i = 1'b0, we_i = 1'b0;
  logic [7:0] dat_o;
  logic       ack_o, clk_out;
  int         n_pass = 0, n_chk = 0;
  logic [7:0] regs [0:4];
  glitch_wishbone dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(dat_i), .adr_i(adr_i), .dat_o(dat_o),
    .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o), .clk_in(clk_in), .clk_out(clk_out)
  );
  initial forever #10 clk_i = ~clk_i;
  initial begin
    #1;
    forever #6 clk_in = ~clk_in;
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic exp_clk(input logic [7:0] m, input logic ci, input logic win);
    if (!win) return ci;
    case (m[1:0])
      2'd1: return 1'b0;
      2'd2: return 1'b1;
`ifdef GLITCH_NOT_MODE_EN
      2'd3: return ~ci;
`endif
      default: return ci;
    endcase
  endfunction
  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    if (a == 4'd0) return 8'h01;
    if (a <= 4'd4) return regs[a];
    return 8'h00;
  endfunction
  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    @(posedge clk_i);
    #2;
    chk("wr_ack", {15'd0, ack_o}, 16'd1);
    stb_i = 1'b0; we_i = 1'b0;
    if (a != 4'd0 && a <= 4'd4) regs[a] = d;
  endtask
  task automatic wb_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = 1'b0; adr_i = a;
    @(posedge clk_i);
    #2;
    chk("rd_ack", {15'd0, ack_o}, 16'd1);
    chk(tag, {8'd0, dat_o}, {8'd0, exp});
    stb_i = 1'b0;
  endtask
  // After the trigger edge N, sample k cycles later: glitch window is k in [d, d+w), ready once k-1 >= d+w.
  task automatic run_glitch(input int d, input int w, input logic [7:0] m);
    wb_write(4'd1, d[7:0]);
    wb_write(4'd2, d[15:8]);
    wb_write(4'd3, w[7:0]);
    wb_write(4'd4, m);
    wb_write(4'd0, 8'h01);
    stb_i = 1'b1; we_i = 1'b0; adr_i = 4'd0;
    for (int k = 0; k <= d + w + 2; k++) begin
      chk("clk_out_a", {15'd0, clk_out}, {15'd0, exp_clk(m, clk_in, k >= d && k < d + w)});
      if (k >= 1) chk("status", {8'd0, dat_o}, {15'd0, k - 1 >= d + w});
      #6;
      chk("clk_out_b", {15'd0, clk_out}, {15'd0, exp_clk(m, clk_in, k >= d && k < d + w)});
      @(posedge clk_i);
      #2;
    end
    stb_i = 1'b0;
  endtask
  initial begin
    for (int i = 0; i <= 4; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_ack", {15'd0, ack_o}, 16'd0);
    chk("rst_dat", {8'd0, dat_o}, 16'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("rst_clk", {15'd0, clk_out}, {15'd0, clk_in});
    end
    for (int a = 0; a <= 4; a++) wb_read(a[3:0], exp_rd(a[3:0]), "rst_reg");
    wb_write(4'd1, 8'hAB);
    wb_write(4'd2, 8'hCD);
    wb_write(4'd3, 8'hAF);
    wb_write(4'd4, 8'hDC);
    @(posedge clk_i);
    #2;
    chk("ack_hold", {15'd0, ack_o}, 16'd1);
    @(posedge clk_i);
    #2;
    chk("ack_drop", {15'd0, ack_o}, 16'd0);
    for (int a = 1; a <= 4; a++) wb_read(a[3:0], exp_rd(a[3:0]), "readback");
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(1, 15));
      wb_write(a, 8'($urandom));
      a = 4'($urandom_range(0, 15));
      wb_read(a, exp_rd(a), "rand_reg");
    end
    run_glitch(8, 4, 8'h01);
    run_glitch(0, 8, 8'h02);
    run_glitch(8, 0, 8'h01);
    for (int m = 0; m < 4; m++) run_glitch(4, 4, 8'(m) | 8'hA0);
    for (int i = 0; i < 6; i++)
      run_glitch($urandom_range(0, 12), $urandom_range(0, 8), 8'($urandom));
    wb_write(4'd1, 8'd5);
    wb_write(4'd2, 8'd0);
    wb_write(4'd3, 8'd0);
    wb_write(4'd0, 8'h01);
    wb_write(4'd0, 8'h01);
    repeat (4) @(posedge clk_i);
    wb_read(4'd0, 8'h01, "busy_trig_ignored");
    wb_write(4'd1, 8'd2);
    wb_write(4'd3, 8'd10);
    wb_write(4'd4, 8'h02);
    wb_write(4'd0, 8'h01);
    repeat (5) @(posedge clk_i);
    #2;
    chk("pre_rst_glitch", {15'd0, clk_out}, 16'd1);
    rst_ni = 1'b0;
    for (int i = 0; i <= 4; i++) regs[i] = 8'h00;
    #1;
    chk("rst_mid_clk", {15'd0, clk_out}, {15'd0, clk_in});
    chk("rst_mid_ack", {15'd0, ack_o}, 16'd0);
    #4;
    chk("rst_mid_clk2", {15'd0, clk_out}, {15'd0, clk_in});
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int a = 0; a <= 4; a++) wb_read(a[3:0], exp_rd(a[3:0]), "post_rst_reg");
    #3;
    chk("post_rst_clk", {15'd0, clk_out}, {15'd0, clk_in});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
